// File: rtl/aes_io_sequencer.sv
// Handshake wrapper around the iterative AES-128 core: holds plaintext/key, releases the core, captures the result.
// Optional AES_IO_SKID_EN adds a one-entry input skid slot so the next block can be queued while one is in flight.
module aes_io_sequencer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] plaintext_i,
  input  logic [127:0] key_i,
  output logic         core_rst_no,
  output logic [127:0] core_text_o,
  output logic [127:0] core_key_o,
  input  logic         core_finish_i,
  input  logic [127:0] core_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] ciphertext_o,
  output logic         busy_o,
  output logic         err_o
);

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_e;

  localparam logic [CNT_W-1:0] WdMax  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] WdLast = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             in_ready_q, in_ready_d;
  logic             core_rst_q, core_rst_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [127:0]     text_q, text_d;
  logic [127:0]     key_q, key_d;
  logic [127:0]     ct_q, ct_d;
  logic             accept;

  assign accept = in_valid_i & in_ready_q;

`ifdef AES_IO_SKID_EN
  logic         slot_v_q, slot_v_d;
  logic [127:0] slot_text_q, slot_text_d;
  logic [127:0] slot_key_q, slot_key_d;
`endif

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    err_d   = err_q;
    text_d  = text_q;
    key_d   = key_q;
    ct_d    = ct_q;
`ifdef AES_IO_SKID_EN
    slot_v_d    = slot_v_q;
    slot_text_d = slot_text_q;
    slot_key_d  = slot_key_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          text_d  = plaintext_i;
          key_d   = key_i;
          wd_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (wd_q < WdMax) wd_d = wd_q + 1'b1;
`ifdef AES_IO_SKID_EN
        if (accept) begin
          slot_v_d    = 1'b1;
          slot_text_d = plaintext_i;
          slot_key_d  = key_i;
        end
`endif
        // A finish landing on the last allowed cycle still counts as success.
        if (core_finish_i) begin
          ct_d    = core_data_i;
          state_d = OUT;
        end else if (wd_q >= WdLast) begin
          err_d   = 1'b1;
          state_d = IDLE;
`ifdef AES_IO_SKID_EN
          slot_v_d = 1'b0;
`endif
        end
      end
      OUT: begin
`ifdef AES_IO_SKID_EN
        if (out_ready_i) begin
          if (slot_v_q) begin
            text_d   = slot_text_q;
            key_d    = slot_key_q;
            slot_v_d = 1'b0;
            wd_d     = '0;
            state_d  = RUN;
          end else if (accept) begin
            // Slot is empty, so a block arriving on the exit cycle goes straight to the core.
            text_d  = plaintext_i;
            key_d   = key_i;
            wd_d    = '0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end else if (accept) begin
          slot_v_d    = 1'b1;
          slot_text_d = plaintext_i;
          slot_key_d  = key_i;
        end
`else
        if (out_ready_i) state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    core_rst_d  = (state_d == RUN);
    out_valid_d = (state_d == OUT);
    busy_d      = (state_d != IDLE);
`ifdef AES_IO_SKID_EN
    in_ready_d  = ~slot_v_d;
`else
    in_ready_d  = (state_d == IDLE);
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      wd_q        <= '0;
      in_ready_q  <= 1'b1;
      core_rst_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      text_q      <= '0;
      key_q       <= '0;
      ct_q        <= '0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      in_ready_q  <= in_ready_d;
      core_rst_q  <= core_rst_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      text_q      <= text_d;
      key_q       <= key_d;
      ct_q        <= ct_d;
    end
  end

`ifdef AES_IO_SKID_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_v_q    <= 1'b0;
      slot_text_q <= '0;
      slot_key_q  <= '0;
    end else begin
      slot_v_q    <= slot_v_d;
      slot_text_q <= slot_text_d;
      slot_key_q  <= slot_key_d;
    end
  end
`endif

  assign in_ready_o   = in_ready_q;
  assign core_rst_no  = core_rst_q;
  assign core_text_o  = text_q;
  assign core_key_o   = key_q;
  assign out_valid_o  = out_valid_q;
  assign ciphertext_o = ct_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_aes_io_sequencer.sv
// Self-checking bench for aes_io_sequencer with a behavioural AES core stand-in (finish 11 cycles after release).
module tb_aes_io_sequencer;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  logic [127:0] plaintext_i = '0;
  logic [127:0] key_i = '0;
  logic         core_rst_no;
  logic [127:0] core_text_o;
  logic [127:0] core_key_o;
  logic         core_finish_i = 1'b0;
  logic [127:0] core_data_i = '0;
  logic         out_valid_o;
  logic         out_ready_i = 1'b0;
  logic [127:0] ciphertext_o;
  logic         busy_o;
  logic         err_o;

  int checks = 0;
  int failures = 0;

  // core model controls
  bit fin_en = 1'b1;
  bit spur_req = 1'b0;
  bit spur_in_hold = 1'b0;
  int run_cnt = 0;

  aes_io_sequencer #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .plaintext_i(plaintext_i), .key_i(key_i),
    .core_rst_no(core_rst_no), .core_text_o(core_text_o), .core_key_o(core_key_o),
    .core_finish_i(core_finish_i), .core_data_i(core_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .ciphertext_o(ciphertext_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stand-in for AES-128: the FIPS-197 vector for the known pair, a keyed mix otherwise.
  function automatic logic [127:0] ref_ct(input logic [127:0] pt, input logic [127:0] k);
    if (pt == 128'h00112233445566778899aabbccddeeff && k == 128'h000102030405060708090a0b0c0d0e0f)
      return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    return pt ^ {k[63:0], k[127:64]} ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  // Core: counts cycles since release; finishes in its 11th released cycle (T+11).
  always @(posedge clk_i) begin
    #1;
    if (core_rst_no) run_cnt = run_cnt + 1;
    else run_cnt = 0;
    if (spur_req) begin
      core_finish_i = 1'b1;
      core_data_i   = rnd128();
    end else if (core_rst_no && fin_en && run_cnt == 11) begin
      core_finish_i = 1'b1;
      core_data_i   = ref_ct(core_text_o, core_key_o);
    end else begin
      core_finish_i = 1'b0;
      core_data_i   = rnd128();
    end
  end

  task automatic run_block(input logic [127:0] pt, input logic [127:0] k, input int hold);
    int w;
    int lat;
    logic [127:0] exp_ct;
    exp_ct = ref_ct(pt, k);
    w = 0;
    while (!in_ready_o && w < 50) begin
      @(negedge clk_i);
      w++;
    end
    checks++;
    if (!in_ready_o) begin
      failures++;
      $display("FAIL blk_ready_wait in_ready=%0b required 1", in_ready_o);
    end
    in_valid_i = 1'b1; plaintext_i = pt; key_i = k;
    @(negedge clk_i);
    in_valid_i = 1'b0; plaintext_i = rnd128(); key_i = rnd128();
    lat = 1;
    while (!out_valid_o && lat < 40) begin
      checks++;
      if (core_rst_no !== (lat <= 11)) begin
        failures++;
        $display("FAIL blk_core_rst cyc=T+%0d got %0b required %0b", lat, core_rst_no, lat <= 11);
      end
      checks++;
      if (core_text_o !== pt || core_key_o !== k) begin
        failures++;
        $display("FAIL blk_hold cyc=T+%0d text=%h key=%h required %h %h", lat, core_text_o, core_key_o, pt, k);
      end
      @(negedge clk_i);
      lat++;
    end
    checks++;
    if (lat != 12) begin
      failures++;
      $display("FAIL blk_latency got %0d required 12", lat);
    end
    checks++;
    if (core_rst_no !== 1'b0) begin
      failures++;
      $display("FAIL blk_core_rst_out got %0b required 0", core_rst_no);
    end
    for (int i = 0; i < hold; i++) begin
      if (spur_in_hold && i == 0) spur_req = 1'b1;
      if (spur_in_hold && i == 1) spur_req = 1'b0;
      checks++;
      if (out_valid_o !== 1'b1 || ciphertext_o !== exp_ct) begin
        failures++;
        $display("FAIL blk_out_stable hold=%0d valid=%0b ct=%h required 1 %h", i, out_valid_o, ciphertext_o, exp_ct);
      end
`ifndef AES_IO_SKID_EN
      checks++;
      if (in_ready_o !== 1'b0) begin
        failures++;
        $display("FAIL blk_in_ready_out got %0b required 0", in_ready_o);
      end
`endif
      @(negedge clk_i);
    end
    spur_req = 1'b0;
    checks++;
    if (out_valid_o !== 1'b1 || ciphertext_o !== exp_ct) begin
      failures++;
      $display("FAIL blk_ct valid=%0b ct=%h required 1 %h", out_valid_o, ciphertext_o, exp_ct);
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL blk_handshake valid=%0b busy=%0b required 0 0", out_valid_o, busy_o);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (in_ready_o !== 1'b1 || core_rst_no !== 1'b0 || out_valid_o !== 1'b0 ||
        busy_o !== 1'b0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL %s ctrl rdy=%0b crst=%0b ov=%0b busy=%0b err=%0b required 1 0 0 0 0",
               tag, in_ready_o, core_rst_no, out_valid_o, busy_o, err_o);
    end
    checks++;
    if (core_text_o !== '0 || core_key_o !== '0 || ciphertext_o !== '0) begin
      failures++;
      $display("FAIL %s data text=%h key=%h ct=%h required zeros", tag, core_text_o, core_key_o, ciphertext_o);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    check_reset_values("reset");
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_single();
    run_block(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, 0);
  endtask

  task automatic test_backpressure();
    spur_in_hold = 1'b1;
    run_block(rnd128(), rnd128(), 20);
    spur_in_hold = 1'b0;
  endtask

  task automatic test_spurious_idle();
    logic [127:0] ct_before;
    ct_before = ciphertext_o;
    spur_req = 1'b1;
    @(negedge clk_i);
    spur_req = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0 || in_ready_o !== 1'b1 || ciphertext_o !== ct_before) begin
      failures++;
      $display("FAIL spur_idle busy=%0b rdy=%0b ct=%h required 0 1 %h", busy_o, in_ready_o, ciphertext_o, ct_before);
    end
  endtask

  task automatic test_timeout();
    int lat;
    bit saw_valid;
    fin_en = 1'b0;
    saw_valid = 1'b0;
    in_valid_i = 1'b1; plaintext_i = rnd128(); key_i = rnd128();
    @(negedge clk_i);
    in_valid_i = 1'b0;
    lat = 1;
    while (!err_o && lat < 40) begin
      if (out_valid_o) saw_valid = 1'b1;
      @(negedge clk_i);
      lat++;
    end
    checks++;
    if (lat != 17) begin
      failures++;
      $display("FAIL timeout_cycle err at T+%0d required T+17", lat);
    end
    checks++;
    if (busy_o !== 1'b0 || in_ready_o !== 1'b1 || core_rst_no !== 1'b0 || saw_valid) begin
      failures++;
      $display("FAIL timeout_idle busy=%0b rdy=%0b crst=%0b saw_valid=%0b required 0 1 0 0",
               busy_o, in_ready_o, core_rst_no, saw_valid);
    end
    fin_en = 1'b1;
    run_block(rnd128(), rnd128(), 1);
    checks++;
    if (err_o !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky err=%0b required 1", err_o);
    end
  endtask

  task automatic test_reset_midrun();
    in_valid_i = 1'b1; plaintext_i = rnd128(); key_i = rnd128();
    @(negedge clk_i);
    in_valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    checks++;
    if (core_rst_no !== 1'b1 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL midrun_busy crst=%0b busy=%0b required 1 1", core_rst_no, busy_o);
    end
    rst_ni = 1'b0;
    #1;
    check_reset_values("midrun_reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    run_block(rnd128(), rnd128(), 2);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
      run_block(rnd128(), rnd128(), int'($urandom_range(0, 3)));
    end
  endtask

`ifdef AES_IO_SKID_EN
  task automatic test_back_to_back();
    logic [127:0] pa, ka, pb, kb;
    int t0, c;
    int out_cyc[$];
    logic [127:0] out_ct[$];
    pa = rnd128(); ka = rnd128(); pb = rnd128(); kb = rnd128();
    out_ready_i = 1'b1;
    in_valid_i = 1'b1; plaintext_i = pa; key_i = ka;
    @(negedge clk_i);
    t0 = 0;
    checks++;
    if (in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready_run got %0b required 1", in_ready_o);
    end
    plaintext_i = pb; key_i = kb;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    c = 2;
    while (c < 60) begin
      if (out_valid_o) begin
        out_cyc.push_back(c);
        out_ct.push_back(ciphertext_o);
      end
      @(negedge clk_i);
      c++;
    end
    out_ready_i = 1'b0;
    checks++;
    if (out_cyc.size() != 2) begin
      failures++;
      $display("FAIL b2b_count got %0d required 2", out_cyc.size());
    end else begin
      checks++;
      if (out_cyc[0] != t0 + 12 || out_cyc[1] != out_cyc[0] + 12) begin
        failures++;
        $display("FAIL b2b_timing got T+%0d T+%0d required T+12 T+24", out_cyc[0], out_cyc[1]);
      end
      checks++;
      if (out_ct[0] !== ref_ct(pa, ka) || out_ct[1] !== ref_ct(pb, kb)) begin
        failures++;
        $display("FAIL b2b_data got %h %h required %h %h", out_ct[0], out_ct[1], ref_ct(pa, ka), ref_ct(pb, kb));
      end
    end
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk_i);
    test_reset();
    test_single();
    test_backpressure();
    test_spurious_idle();
    test_timeout();
    test_reset_midrun();
    test_random();
`ifdef AES_IO_SKID_EN
    test_back_to_back();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
